// File: rtl/alsu_driver_pkg.sv
// Shared types for the ALSU driver: opcode encoding, drive payload and result entry.
package alsu_driver_pkg;

  localparam int unsigned OPND_W = 3;
  localparam int unsigned CIN_W  = 2;
  localparam int unsigned RES_W  = 6;

  typedef enum logic [2:0] {
    OR        = 3'd0,
    XOR       = 3'd1,
    ADD       = 3'd2,
    MULT      = 3'd3,
    SHIFT     = 3'd4,
    ROTATE    = 3'd5,
    INVALID_6 = 3'd6,
    INVALID_7 = 3'd7
  } opcode_e;

  // Full set of values driven onto the ALSU inputs.
  typedef struct packed {
    logic signed [OPND_W-1:0] a;
    logic signed [OPND_W-1:0] b;
    opcode_e                  opcode;
    logic signed [CIN_W-1:0]  cin;
    logic                     bypass_a;
    logic                     bypass_b;
    logic                     red_op_a;
    logic                     red_op_b;
    logic                     direction;
    logic                     serial_in;
  } alsu_cmd_t;

  // One result FIFO entry.
  typedef struct packed {
    logic signed [RES_W-1:0] data;
    opcode_e                 opcode;
  } alsu_res_t;

  localparam alsu_cmd_t CMD_RESET = '{
    a: '0, b: '0, opcode: OR, cin: '0,
    bypass_a: 1'b0, bypass_b: 1'b0, red_op_a: 1'b0, red_op_b: 1'b0,
    direction: 1'b0, serial_in: 1'b0
  };

endpackage

// File: rtl/alsu_driver_if.sv
// Command and result handshake bundle of the ALSU driver.
//   cmd_*  : command offer (valid/ready) with operands and control bits
//   res_*  : result FIFO head (valid/ready) with data and opcode
interface alsu_driver_if;
  import alsu_driver_pkg::*;

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic signed [OPND_W-1:0] cmd_A;
  logic signed [OPND_W-1:0] cmd_B;
  opcode_e                  cmd_opcode;
  logic signed [CIN_W-1:0]  cmd_cin;
  logic                     cmd_bypass_A;
  logic                     cmd_bypass_B;
  logic                     cmd_red_op_A;
  logic                     cmd_red_op_B;
  logic                     cmd_direction;
  logic                     cmd_serial_in;

  logic                     res_valid;
  logic                     res_ready;
  logic signed [RES_W-1:0]  res_data;
  opcode_e                  res_opcode;

  modport slave (
    input  cmd_valid, cmd_A, cmd_B, cmd_opcode, cmd_cin,
           cmd_bypass_A, cmd_bypass_B, cmd_red_op_A, cmd_red_op_B,
           cmd_direction, cmd_serial_in, res_ready,
    output cmd_ready, res_valid, res_data, res_opcode
  );

  modport master (
    output cmd_valid, cmd_A, cmd_B, cmd_opcode, cmd_cin,
           cmd_bypass_A, cmd_bypass_B, cmd_red_op_A, cmd_red_op_B,
           cmd_direction, cmd_serial_in, res_ready,
    input  cmd_ready, res_valid, res_data, res_opcode
  );

endinterface

// File: rtl/alsu_res_fifo.sv
// Result FIFO: DEPTH entries (power of two, >= 2) of {data, opcode}.
//   push_i/push_data_i : write an entry
//   pop_i              : remove the head (ignored when empty)
//   head_o, empty_o    : head entry and empty flag
//   count_o            : registered occupancy
module alsu_res_fifo
  import alsu_driver_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  alsu_res_t                push_data_i,
  input  logic                     pop_i,
  output alsu_res_t                head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  alsu_res_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_pop;

  // Pointer/count next state; pointers wrap naturally at DEPTH.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty_o  = (count_q == '0);
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Credit flow control upstream must make this unreachable.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push_i && full && !do_pop))
    else $error("alsu_res_fifo: push into full FIFO");

endmodule

// File: rtl/alsu_driver.sv
// Drives commands into a fixed-latency ALSU and collects its results in order.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : command/result handshake (slave side)
//   A .. serial_in : registered drive to the ALSU inputs
//   alsu_out     : ALSU output register, sampled LATENCY+1 edges after acceptance
//   idle         : nothing in flight and result FIFO empty
module alsu_driver
  import alsu_driver_pkg::*;
#(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  alsu_driver_if.slave             bus,
  output logic signed [OPND_W-1:0] A,
  output logic signed [OPND_W-1:0] B,
  output opcode_e                  opcode,
  output logic signed [CIN_W-1:0]  cin,
  output logic                     bypass_A,
  output logic                     bypass_B,
  output logic                     red_op_A,
  output logic                     red_op_B,
  output logic                     direction,
  output logic                     serial_in,
  input  logic signed [RES_W-1:0]  alsu_out,
  output logic                     idle
);

  localparam int unsigned PIPE_N = LATENCY + 1;
  localparam int unsigned CNT_W  = $clog2(RES_DEPTH) + 1;
  localparam int unsigned SUM_W  = CNT_W + 1;

  alsu_cmd_t         drive_q, drive_d, cmd_in;
  logic [PIPE_N-1:0] pipe_vld_q, pipe_vld_d;
  opcode_e           pipe_op_q [PIPE_N];
  opcode_e           pipe_op_d [PIPE_N];
  logic [CNT_W-1:0]  in_flight_q, in_flight_d;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  alsu_res_t         fifo_head;
  alsu_res_t         push_data;
  logic              accept;
  logic              push;

  // A credit is held from acceptance until the result leaves the FIFO.
  assign bus.cmd_ready = (SUM_W'(in_flight_q) + SUM_W'(fifo_count)) < SUM_W'(RES_DEPTH);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign push          = pipe_vld_q[LATENCY];
  assign push_data     = '{data: alsu_out, opcode: pipe_op_q[LATENCY]};

  assign cmd_in = '{
    a: bus.cmd_A, b: bus.cmd_B, opcode: bus.cmd_opcode, cin: bus.cmd_cin,
    bypass_a: bus.cmd_bypass_A, bypass_b: bus.cmd_bypass_B,
    red_op_a: bus.cmd_red_op_A, red_op_b: bus.cmd_red_op_B,
    direction: bus.cmd_direction, serial_in: bus.cmd_serial_in
  };

  // Drive hold, in-flight shift pipeline and in-flight count.
  always_comb begin
    drive_d      = drive_q;
    pipe_vld_d   = pipe_vld_q;
    pipe_op_d    = pipe_op_q;
    in_flight_d  = in_flight_q + CNT_W'(accept) - CNT_W'(push);
    if (accept) drive_d = cmd_in;
    pipe_vld_d[0] = accept;
    pipe_op_d[0]  = bus.cmd_opcode;
    for (int unsigned i = 1; i < PIPE_N; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_op_d[i]  = pipe_op_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drive_q     <= CMD_RESET;
      pipe_vld_q  <= '0;
      in_flight_q <= '0;
      for (int unsigned i = 0; i < PIPE_N; i++) pipe_op_q[i] <= OR;
    end else begin
      drive_q     <= drive_d;
      pipe_vld_q  <= pipe_vld_d;
      in_flight_q <= in_flight_d;
      pipe_op_q   <= pipe_op_d;
    end
  end

  alsu_res_fifo #(.DEPTH(RES_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (bus.res_ready),
    .head_o     (fifo_head),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign bus.res_valid  = !fifo_empty;
  assign bus.res_data   = fifo_head.data;
  assign bus.res_opcode = fifo_head.opcode;
  assign idle           = (in_flight_q == '0) && fifo_empty;

  assign A         = drive_q.a;
  assign B         = drive_q.b;
  assign opcode    = drive_q.opcode;
  assign cin       = drive_q.cin;
  assign bypass_A  = drive_q.bypass_a;
  assign bypass_B  = drive_q.bypass_b;
  assign red_op_A  = drive_q.red_op_a;
  assign red_op_B  = drive_q.red_op_b;
  assign direction = drive_q.direction;
  assign serial_in = drive_q.serial_in;

endmodule

// File: tb/tb_alsu_driver.sv
// Bench for alsu_driver with a two-stage behavioural ALSU and a result scoreboard.
module tb_alsu_driver;
  import alsu_driver_pkg::*;

  localparam int unsigned LATENCY   = 2;
  localparam int unsigned RES_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alsu_driver_if bus ();

  logic signed [2:0] A, B;
  opcode_e           opcode;
  logic signed [1:0] cin;
  logic              bypass_A, bypass_B, red_op_A, red_op_B, direction, serial_in;
  logic signed [5:0] alsu_out;
  logic              idle;

  alsu_driver #(.LATENCY(LATENCY), .RES_DEPTH(RES_DEPTH)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .A        (A),
    .B        (B),
    .opcode   (opcode),
    .cin      (cin),
    .bypass_A (bypass_A),
    .bypass_B (bypass_B),
    .red_op_A (red_op_A),
    .red_op_B (red_op_B),
    .direction(direction),
    .serial_in(serial_in),
    .alsu_out (alsu_out),
    .idle     (idle)
  );

  // Reference ALSU arithmetic for the opcodes this bench issues.
  function automatic logic signed [5:0] alsu_calc(opcode_e op, logic signed [2:0] a,
                                                  logic signed [2:0] b, logic signed [1:0] c);
    int r;
    case (op)
      OR:      r = int'(a | b);
      XOR:     r = int'(a ^ b);
      ADD:     r = int'(a) + int'(b) + int'(c);
      MULT:    r = int'(a) * int'(b);
      default: r = 0;
    endcase
    return 6'(r);
  endfunction

  // Behavioural ALSU: input register stage then output register stage.
  logic signed [2:0] s_a, s_b;
  opcode_e           s_op;
  logic signed [1:0] s_cin;
  always @(posedge clk) begin
    if (rst) begin
      s_a <= '0; s_b <= '0; s_op <= OR; s_cin <= '0; alsu_out <= '0;
    end else begin
      s_a <= A; s_b <= B; s_op <= opcode; s_cin <= cin;
      alsu_out <= alsu_calc(s_op, s_a, s_b, s_cin);
    end
  end

  typedef struct {
    logic signed [5:0] data;
    opcode_e           op;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Result monitor: compares the head against the scoreboard whenever a pop will happen.
  always begin
    @(negedge clk);
    #2;
    if (rst === 1'b0 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("res_unexpected", 32'(bus.res_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("res_data", 32'(bus.res_data), 32'(e.data));
        check_eq("res_opcode", 32'(bus.res_opcode), 32'(e.op));
      end
    end
  end

  task automatic drive_cmd(input opcode_e op, input logic signed [2:0] a,
                           input logic signed [2:0] b, input logic signed [1:0] c);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_A      = a;
    bus.cmd_B      = b;
    bus.cmd_cin    = c;
  endtask

  // Offer one command, wait (bounded) for acceptance, record its expected result.
  task automatic issue(input opcode_e op, input logic signed [2:0] a, input logic signed [2:0] b,
                       input logic signed [1:0] c, input logic signed [5:0] exp_data);
    int unsigned budget;
    budget = 0;
    @(negedge clk);
    drive_cmd(op, a, b, c);
    #1;
    while (bus.cmd_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      check_eq("accept_timeout", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b0;
    end else begin
      sb_q.push_back('{data: exp_data, op: op});
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    bus.res_ready = 1'b1;
    while ((sb_q.size() != 0 || idle !== 1'b1) && n < 40) begin
      @(negedge clk);
      #3;
      n++;
    end
    check_eq("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("drain_idle", 32'(idle), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst               = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_A         = '0;
    bus.cmd_B         = '0;
    bus.cmd_opcode    = XOR;
    bus.cmd_cin       = '0;
    bus.cmd_bypass_A  = 1'b0;
    bus.cmd_bypass_B  = 1'b0;
    bus.cmd_red_op_A  = 1'b0;
    bus.cmd_red_op_B  = 1'b0;
    bus.cmd_direction = 1'b0;
    bus.cmd_serial_in = 1'b0;
    bus.res_ready     = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_opcode", 32'(opcode), 32'(OR));
    check_eq("rst_A", 32'(A), 32'd0);
    check_eq("rst_cin", 32'(cin), 32'd0);
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check_eq("rst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // ADD 3+2+1 with exact latency check
    issue(ADD, 3'sd3, 3'sd2, 2'sd1, 6'sd6);
    check_eq("add_drive_A", 32'(A), 32'd3);
    check_eq("add_idle_busy", 32'(idle), 32'd0);
    @(posedge clk); #1;
    check_eq("add_lat_n1", 32'(bus.res_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("add_lat_n2", 32'(bus.res_valid), 32'd0);
    check_eq("hold_opcode", 32'(opcode), 32'(ADD));
    check_eq("hold_B", 32'(B), 32'd2);
    @(posedge clk); #1;
    check_eq("add_lat_n3", 32'(bus.res_valid), 32'd1);
    check_eq("add_res_data", 32'(bus.res_data), 32'(6'b000110));
    check_eq("add_res_opcode", 32'(bus.res_opcode), 32'(ADD));
    wait_drain();

    // MULT -2*3
    issue(MULT, -3'sd2, 3'sd3, 2'sd0, -6'sd6);
    wait_drain();

    // Back-to-back random stream
    for (int i = 0; i < 10; i++) begin
      opcode_e           op;
      logic signed [2:0] ra, rb;
      logic signed [1:0] rc;
      op = opcode_e'($urandom_range(0, 3));
      ra = 3'($urandom);
      rb = 3'($urandom);
      rc = 2'($urandom);
      issue(op, ra, rb, rc, alsu_calc(op, ra, rb, rc));
    end
    wait_drain();

    // Backpressure: offer every cycle with res_ready low
    @(negedge clk);
    bus.res_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      logic signed [2:0] ra;
      @(negedge clk);
      ra = 3'(i);
      drive_cmd(ADD, ra, 3'sd1, 2'sd0);
      #1;
      if (bus.cmd_ready === 1'b1) begin
        acc++;
        sb_q.push_back('{data: alsu_calc(ADD, ra, 3'sd1, 2'sd0), op: ADD});
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check_eq("bp_accepted", 32'(acc), 32'd4);
    check_eq("bp_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("bp_res_valid", 32'(bus.res_valid), 32'd1);
    check_eq("bp_fifo_full", 32'(u_dut.u_fifo.count_q), 32'd4);
    bus.res_ready = 1'b1;
    #1;
    check_eq("bp_ready_before_pop", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check_eq("bp_ready_after_pop", 32'(bus.cmd_ready), 32'd1);

    // Push and pop on the same edge while all credits are taken
    issue(XOR, 3'sd1, -3'sd1, 2'sd0, alsu_calc(XOR, 3'sd1, -3'sd1, 2'sd0));
    check_eq("pp_cmd_ready_full", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    check_eq("pp_count_before", 32'(u_dut.u_fifo.count_q), 32'd3);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check_eq("pp_count_after", 32'(u_dut.u_fifo.count_q), 32'd3);
    check_eq("pp_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    wait_drain();

    // Reset one cycle after acceptance discards the command
    issue(ADD, 3'sd1, 3'sd2, 2'sd0, alsu_calc(ADD, 3'sd1, 3'sd2, 2'sd0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    check_eq("mid_rst_idle", 32'(idle), 32'd1);
    check_eq("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("mid_rst_no_res", 32'(bus.res_valid), 32'd0);
    end

    // Recovery after reset
    issue(OR, 3'sd2, 3'sd1, 2'sd0, alsu_calc(OR, 3'sd2, 3'sd1, 2'sd0));
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
